// File: rtl/ysyx_22050019_dmem_axi_bridge.sv
// ----------------------------------------------------------------------------
// ysyx_22050019_dmem_axi_bridge
//
// Converts the LSU's level-style data-memory request into single AXI4-Lite
// read or write transactions. One transaction is outstanding at a time; the
// pipeline is held through stall_o until the transaction ends, which is
// marked by a one-cycle done_o pulse (with err_o qualifying it).
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   req_valid_i             MEM stage holds a valid instruction
//   ram_re_i / ram_we_i     load / store request (store wins if both set)
//   ram_addr_i[63:0]        byte address
//   ram_wdata_i[63:0]       store data, low-aligned
//   wmask_i[7:0]            store byte mask, low-aligned
//   ram_rdata_o[63:0]       load data shifted down to byte lane 0
//   done_o, err_o           end-of-transaction pulse and its error flag
//   stall_o                 pipeline hold
//   m_axi_aw*/w*/b*/ar*/r*  AXI4-Lite master channels
//   dbg_state[2:0]          current FSM state, for observation only
//
// Handshake rule on every AXI channel: a beat transfers on a rising edge
// where both valid and ready are 1. A raised valid, and the payload it
// qualifies, stay unchanged until that edge; valid never waits on ready.
// ----------------------------------------------------------------------------
module ysyx_22050019_dmem_axi_bridge #(
    parameter int ADDR_W      = 32,
    parameter bit ALIGN_ADDR  = 1'b1,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    input  logic              ram_re_i,
    input  logic              ram_we_i,
    input  logic [63:0]       ram_addr_i,
    input  logic [63:0]       ram_wdata_i,
    input  logic [7:0]        wmask_i,
    output logic [63:0]       ram_rdata_o,
    output logic              done_o,
    output logic              err_o,
    output logic              stall_o,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    output logic [63:0]       m_axi_wdata,
    output logic [7:0]        m_axi_wstrb,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    input  logic [1:0]        m_axi_bresp,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [63:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    localparam bit          TMO_EN   = (TIMEOUT_CYC > 0);
    localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(TIMEOUT_CYC - 1) : 32'd0;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;     // issued address, already aligned if enabled
    logic [2:0]        off_q;      // byte offset used to realign load data
    logic              both_q;     // re & we were both set at accept
    logic              aw_done;
    logic              w_done;
    logic [31:0]       tmo_cnt;    // cycles spent in the current state

    logic              req_go;
    logic [ADDR_W-1:0] req_addr;
    logic              tmo_hit;
    logic              aw_fire;
    logic              w_fire;
    logic              aw_now;
    logic              w_now;
    logic              unused_addr;

    // A request is taken only in IDLE and never in the done_o cycle, so the
    // pipeline sees exactly one un-stalled cycle per completed transaction.
    assign req_go = (state == IDLE) & req_valid_i & (ram_re_i | ram_we_i) & ~done_o;

    always_comb begin
        req_addr = ram_addr_i[ADDR_W-1:0];
        if (ALIGN_ADDR) begin
            req_addr[2:0] = 3'b000;
        end
    end

    // Bits above ADDR_W are intentionally dropped.
    assign unused_addr = ^ram_addr_i;

    // The abort fires on the edge at which the counter would reach TIMEOUT_CYC.
    assign tmo_hit = TMO_EN && (tmo_cnt == TMO_LAST);

    assign aw_fire = m_axi_awvalid & m_axi_awready;
    assign w_fire  = m_axi_wvalid & m_axi_wready;
    assign aw_now  = aw_done | aw_fire;
    assign w_now   = w_done | w_fire;

    assign stall_o      = (state != IDLE) | req_go;
    assign m_axi_araddr = addr_q;
    assign m_axi_awaddr = addr_q;
    assign dbg_state    = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr_q        <= '0;
            off_q         <= 3'd0;
            both_q        <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            tmo_cnt       <= 32'd0;
            ram_rdata_o   <= 64'd0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wdata   <= 64'd0;
            m_axi_wstrb   <= 8'd0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= 32'd0;
                    if (req_go) begin
                        addr_q      <= req_addr;
                        off_q       <= ram_addr_i[2:0];
                        both_q      <= ram_re_i & ram_we_i;
                        // Lane-align store data and mask; anything pushed
                        // past lane 7 falls off the top.
                        m_axi_wdata <= ram_wdata_i << {ram_addr_i[2:0], 3'b000};
                        m_axi_wstrb <= wmask_i << ram_addr_i[2:0];
                        if (ram_we_i) begin
                            state         <= WR_REQ;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                        end else begin
                            state         <= RD_ADDR;
                            m_axi_arvalid <= 1'b1;
                        end
                    end
                end

                RD_ADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD_DATA;
                        tmo_cnt       <= 32'd0;
                    end else if (tmo_hit) begin
                        m_axi_arvalid <= 1'b0;
                        done_o        <= 1'b1;
                        err_o         <= 1'b1;
                        state         <= IDLE;
                        tmo_cnt       <= 32'd0;
                    end else if (TMO_EN) begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end

                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        ram_rdata_o  <= m_axi_rdata >> {off_q, 3'b000};
                        done_o       <= 1'b1;
                        err_o        <= (m_axi_rresp != 2'b00);
                        state        <= IDLE;
                        tmo_cnt      <= 32'd0;
                    end else if (tmo_hit) begin
                        m_axi_rready <= 1'b0;
                        done_o       <= 1'b1;
                        err_o        <= 1'b1;
                        state        <= IDLE;
                        tmo_cnt      <= 32'd0;
                    end else if (TMO_EN) begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end

                WR_REQ: begin
                    // AW and W complete independently; each valid drops
                    // right after its own handshake.
                    if (aw_fire) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_fire) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if (aw_now && w_now) begin
                        m_axi_bready <= 1'b1;
                        state        <= WR_RESP;
                        tmo_cnt      <= 32'd0;
                    end else if (tmo_hit) begin
                        m_axi_awvalid <= 1'b0;
                        m_axi_wvalid  <= 1'b0;
                        done_o        <= 1'b1;
                        err_o         <= 1'b1;
                        state         <= IDLE;
                        tmo_cnt       <= 32'd0;
                    end else if (TMO_EN) begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end

                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        done_o       <= 1'b1;
                        // A request that had both re and we set reports an
                        // error even though the store itself went out.
                        err_o        <= (m_axi_bresp != 2'b00) | both_q;
                        state        <= IDLE;
                        tmo_cnt      <= 32'd0;
                    end else if (tmo_hit) begin
                        m_axi_bready <= 1'b0;
                        done_o       <= 1'b1;
                        err_o        <= 1'b1;
                        state        <= IDLE;
                        tmo_cnt      <= 32'd0;
                    end else if (TMO_EN) begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end

                default: begin
                    m_axi_awvalid <= 1'b0;
                    m_axi_wvalid  <= 1'b0;
                    m_axi_bready  <= 1'b0;
                    m_axi_arvalid <= 1'b0;
                    m_axi_rready  <= 1'b0;
                    state         <= IDLE;
                    tmo_cnt       <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050019_dmem_axi_bridge.sv
// ----------------------------------------------------------------------------
// Bench for ysyx_22050019_dmem_axi_bridge. Two instances share the request
// and slave-side inputs: "dut" uses default parameters and is checked on
// every transaction; "dut_to" uses TIMEOUT_CYC=4 and is checked in the
// timeout and reset sequences. Inputs change on the falling edge and
// outputs are sampled 1 time unit later.
// ----------------------------------------------------------------------------
module tb_ysyx_22050019_dmem_axi_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, ram_re, ram_we;
    logic [63:0] ram_addr, ram_wdata;
    logic [7:0]  wmask;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [63:0] rdata;

    logic [63:0] ram_rdata, m_wdata;
    logic        done, err, stall, awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] awaddr, araddr;
    logic [7:0]  wstrb;
    logic [2:0]  dbg_state;

    logic [63:0] t_ram_rdata, t_wdata;
    logic        t_done, t_err, t_stall, t_awvalid, t_wvalid, t_bready, t_arvalid, t_rready;
    logic [31:0] t_awaddr, t_araddr;
    logic [7:0]  t_wstrb;
    logic [2:0]  t_dbg_state;

    int checks = 0;
    int errors = 0;
    logic [63:0] model_rdata;
    logic [63:0] exp_q[$];

    typedef struct {
        logic        re, we;
        logic [63:0] addr, wdata, rdata;
        logic [7:0]  mask;
        logic [1:0]  resp;
        int          ar_wait, r_wait, aw_wait, w_wait, rsp_wait;
        logic [63:0] exp_rdata, exp_wdata;
        logic [7:0]  exp_wstrb;
        logic [31:0] exp_addr;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    ysyx_22050019_dmem_axi_bridge dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .ram_re_i(ram_re), .ram_we_i(ram_we),
        .ram_addr_i(ram_addr), .ram_wdata_i(ram_wdata), .wmask_i(wmask),
        .ram_rdata_o(ram_rdata), .done_o(done), .err_o(err), .stall_o(stall),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(m_wdata), .m_axi_wstrb(wstrb),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .dbg_state(dbg_state)
    );

    ysyx_22050019_dmem_axi_bridge #(.TIMEOUT_CYC(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .ram_re_i(ram_re), .ram_we_i(ram_we),
        .ram_addr_i(ram_addr), .ram_wdata_i(ram_wdata), .wmask_i(wmask),
        .ram_rdata_o(t_ram_rdata), .done_o(t_done), .err_o(t_err), .stall_o(t_stall),
        .m_axi_awvalid(t_awvalid), .m_axi_awready(awready), .m_axi_awaddr(t_awaddr),
        .m_axi_wvalid(t_wvalid), .m_axi_wready(wready), .m_axi_wdata(t_wdata), .m_axi_wstrb(t_wstrb),
        .m_axi_bvalid(bvalid), .m_axi_bready(t_bready), .m_axi_bresp(bresp),
        .m_axi_arvalid(t_arvalid), .m_axi_arready(arready), .m_axi_araddr(t_araddr),
        .m_axi_rvalid(rvalid), .m_axi_rready(t_rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .dbg_state(t_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
        model_rdata = 64'd0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference: computed from the lane rules with plain arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t m;
        int   off;
        m   = v;
        off = int'(v.addr % 64'd8);
        m.exp_wdata = v.wdata << (8 * off);
        m.exp_wstrb = 8'((int'(v.mask) << off) % 256);
        m.exp_rdata = v.rdata >> (8 * off);
        m.exp_addr  = 32'(v.addr) - 32'(off);
        m.exp_err   = (v.resp != 2'd0) || (v.re && v.we);
        return m;
    endfunction

    function automatic vec_t blank();
        vec_t v;
        v.re = 0; v.we = 0; v.addr = 0; v.wdata = 0; v.rdata = 0; v.mask = 0; v.resp = 0;
        v.ar_wait = 0; v.r_wait = 0; v.aw_wait = 0; v.w_wait = 0; v.rsp_wait = 0;
        v.exp_rdata = 0; v.exp_wdata = 0; v.exp_wstrb = 0; v.exp_addr = 0; v.exp_err = 0;
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic run_txn(input vec_t v);
        bit aw_ok, w_ok;
        int n;
        @(negedge clk);
        req_valid = 1'b1; ram_re = v.re; ram_we = v.we;
        ram_addr = v.addr; ram_wdata = v.wdata; wmask = v.mask;
        #1;
        chk("stall_on_request", 64'(stall), 64'd1);
        @(negedge clk);
        // Request stays valid but its payload is scrambled: it must be latched.
        ram_addr  = {$urandom(), $urandom()};
        ram_wdata = {$urandom(), $urandom()};
        wmask     = 8'($urandom());
        if (v.we) begin
            aw_ok = 0; w_ok = 0; n = 0;
            while (!(aw_ok && w_ok) && n < 20) begin
                awready = (n >= v.aw_wait);
                wready  = (n >= v.w_wait);
                #1;
                chk("awvalid", 64'(awvalid), 64'(!aw_ok));
                chk("wvalid", 64'(wvalid), 64'(!w_ok));
                chk("no_ar_on_store", 64'(arvalid), 64'd0);
                chk("stall_store", 64'(stall), 64'd1);
                chk("no_done_store", 64'(done), 64'd0);
                if (!aw_ok) chk("awaddr", 64'(awaddr), 64'(v.exp_addr));
                if (!w_ok) begin
                    chk("wdata", m_wdata, v.exp_wdata);
                    chk("wstrb", 64'(wstrb), 64'(v.exp_wstrb));
                end
                if (awready) aw_ok = 1;
                if (wready) w_ok = 1;
                @(negedge clk);
                n++;
            end
            awready = 1'b0; wready = 1'b0;
            for (int i = 0; i <= v.rsp_wait; i++) begin
                bvalid = (i == v.rsp_wait);
                bresp  = bvalid ? v.resp : 2'($urandom());
                #1;
                chk("bready", 64'(bready), 64'd1);
                chk("aw_w_dropped", 64'({awvalid, wvalid}), 64'd0);
                chk("no_done_before_b", 64'(done), 64'd0);
                @(negedge clk);
            end
            bvalid = 1'b0;
        end else begin
            for (int i = 0; i <= v.ar_wait; i++) begin
                arready = (i == v.ar_wait);
                #1;
                chk("arvalid", 64'(arvalid), 64'd1);
                chk("araddr", 64'(araddr), 64'(v.exp_addr));
                chk("no_aw_on_load", 64'(awvalid), 64'd0);
                chk("stall_load", 64'(stall), 64'd1);
                chk("no_done_ar", 64'(done), 64'd0);
                @(negedge clk);
            end
            arready = 1'b0;
            for (int i = 0; i <= v.r_wait; i++) begin
                rvalid = (i == v.r_wait);
                rdata  = rvalid ? v.rdata : {$urandom(), $urandom()};
                rresp  = v.resp;
                #1;
                chk("rready", 64'(rready), 64'd1);
                chk("ar_dropped", 64'(arvalid), 64'd0);
                chk("no_done_r", 64'(done), 64'd0);
                @(negedge clk);
            end
            rvalid = 1'b0;
            rdata  = {$urandom(), $urandom()};
            model_rdata = v.exp_rdata;
        end
        #1;
        chk("done", 64'(done), 64'd1);
        chk("err", 64'(err), 64'(v.exp_err));
        chk("stall_in_done", 64'(stall), 64'd0);
        exp_q.push_back(model_rdata);
        chk("ram_rdata", ram_rdata, exp_q.pop_front());
        @(negedge clk);
        req_valid = 1'b0; ram_re = 1'b0; ram_we = 1'b0;
        #1;
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("no_accept_in_done", 64'({arvalid, awvalid, wvalid}), 64'd0);
        chk("idle_no_stall", 64'(stall), 64'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t v;
        req_valid = 0; ram_re = 0; ram_we = 0; ram_addr = 0; ram_wdata = 0; wmask = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rresp = 0; rdata = 0;
        rst_n = 1'b0;
        model_rdata = 64'd0;

        // Directed records with hand-derived expectations.
        v = blank(); v.re = 1; v.addr = 64'h8000_0004; v.rdata = 64'h1122_3344_5566_7788;
        v.exp_rdata = 64'h0000_0000_1122_3344; v.exp_addr = 32'h8000_0000; vecs.push_back(v);
        v = blank(); v.we = 1; v.addr = 64'h8000_0003; v.wdata = 64'hAB; v.mask = 8'h01;
        v.aw_wait = 0; v.w_wait = 3; v.rsp_wait = 2;
        v.exp_wdata = 64'h0000_0000_AB00_0000; v.exp_wstrb = 8'h08; v.exp_addr = 32'h8000_0000; vecs.push_back(v);
        v = blank(); v.re = 1; v.addr = 64'h8000_0010; v.rdata = 64'hDEAD_BEEF_CAFE_F00D;
        v.ar_wait = 5; v.r_wait = 2; v.exp_rdata = 64'hDEAD_BEEF_CAFE_F00D; v.exp_addr = 32'h8000_0010; vecs.push_back(v);
        v = blank(); v.re = 1; v.addr = 64'h8000_0007; v.rdata = 64'hA1B2_C3D4_E5F6_0718; v.resp = 2'b10;
        v.exp_rdata = 64'h0000_0000_0000_00A1; v.exp_addr = 32'h8000_0000; v.exp_err = 1; vecs.push_back(v);
        v = blank(); v.re = 1; v.we = 1; v.addr = 64'h8000_0006; v.wdata = 64'h1234; v.mask = 8'h03;
        v.exp_wdata = 64'h1234_0000_0000_0000; v.exp_wstrb = 8'hC0; v.exp_addr = 32'h8000_0000; v.exp_err = 1; vecs.push_back(v);
        v = blank(); v.we = 1; v.addr = 64'h1_8000_000D; v.wdata = 64'h0102_0304_0506_0708; v.mask = 8'hFF;
        v.resp = 2'b01; v.aw_wait = 2; v.w_wait = 0;
        v.exp_wdata = 64'h0607_0800_0000_0000; v.exp_wstrb = 8'hE0; v.exp_addr = 32'h8000_0008; v.exp_err = 1; vecs.push_back(v);

        // Randomized records, expectations from the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] masks [4];
            masks[0] = 8'h01; masks[1] = 8'h03; masks[2] = 8'h0F; masks[3] = 8'hFF;
            v = blank();
            v.we = ($urandom_range(0, 1) == 1);
            v.re = v.we ? ($urandom_range(0, 7) == 0) : 1'b1;
            v.addr = {$urandom(), $urandom()};
            v.wdata = {$urandom(), $urandom()};
            v.rdata = {$urandom(), $urandom()};
            v.mask = masks[$urandom_range(0, 3)];
            v.resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            v.ar_wait = $urandom_range(0, 3); v.r_wait = $urandom_range(0, 3);
            v.aw_wait = $urandom_range(0, 3); v.w_wait = $urandom_range(0, 3);
            v.rsp_wait = $urandom_range(0, 3);
            vecs.push_back(model(v));
        end

        // Reset values.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
        chk("rst_done_err", 64'({done, err}), 64'd0);
        chk("rst_rdata", ram_rdata, 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        chk("rst_to_valids", 64'({t_awvalid, t_wvalid, t_bready, t_arvalid, t_rready, t_done}), 64'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_txn(vecs[i]);

        // Timeout: write response never arrives at dut_to.
        apply_reset(2);
        run_txn(vecs[0]);  // leaves 0x11223344 in both ram_rdata_o registers
        @(negedge clk);
        req_valid = 1; ram_we = 1; ram_re = 0; ram_addr = 64'h8000_0020; ram_wdata = 64'h55; wmask = 8'h01;
        awready = 1; wready = 1; bvalid = 0;
        @(negedge clk);  // accepted
        req_valid = 0; ram_we = 0;
        #1;
        chk("to_aw_w_up", 64'({t_awvalid, t_wvalid}), 64'd3);
        @(negedge clk);  // entered WR_RESP
        awready = 0; wready = 0;
        #1;
        chk("to_bready", 64'(t_bready), 64'd1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            #1;
            chk("to_no_early_done", 64'(t_done), 64'd0);
            chk("to_bready_held", 64'(t_bready), 64'd1);
        end
        @(negedge clk);
        #1;
        chk("to_done", 64'(t_done), 64'd1);
        chk("to_err", 64'(t_err), 64'd1);
        chk("to_bready_dropped", 64'(t_bready), 64'd0);
        chk("to_rdata_kept", t_ram_rdata, 64'h0000_0000_1122_3344);
        chk("main_still_waiting", 64'({bready, done}), 64'd2);
        @(negedge clk);
        bvalid = 1; bresp = 2'b00;
        #1;
        chk("to_done_pulse", 64'(t_done), 64'd0);
        @(negedge clk);
        bvalid = 0;
        #1;
        chk("main_done_after_b", 64'({done, err}), 64'd2);
        @(negedge clk);

        // Reset in the middle of a read.
        req_valid = 1; ram_re = 1; ram_addr = 64'h8000_0040;
        @(negedge clk);
        req_valid = 0; ram_re = 0;
        #1;
        chk("mid_arvalid_up", 64'({arvalid, t_arvalid}), 64'd3);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_arvalid_drop", 64'({arvalid, t_arvalid}), 64'd0);
        chk("mid_no_done", 64'({done, t_done}), 64'd0);
        chk("mid_rdata_cleared", ram_rdata, 64'd0);
        rst_n = 1'b1;
        model_rdata = 64'd0;
        arready = 1; rvalid = 1; rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("post_rst_no_done", 64'({done, t_done, rready, arvalid}), 64'd0);
        end
        arready = 0; rvalid = 0;
        run_txn(vecs[3]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Bound the whole run in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
